sig_ext_stage: RTL and testbench
================================

Name: sig_ext_stage

Overview:
- Registered, parametrised immediate-extension stage for the datapath's decode path.
- Widens an N_BUS_IN-bit immediate field to N_BUS bits using one of four per-transaction modes: zero-extend, sign-extend, upper-place, or sign-extend-and-shift.
- Sits between instruction decode and the ALU/branch operand mux.
- Uses a valid/ready handshake with a 2-entry skid buffer, so it sustains one result per cycle under backpressure with no combinational ready path.

Parameters:
- N_BUS, 16, output width in bits.
- N_BUS_IN, 11, input immediate width in bits. Required: N_BUS_IN < N_BUS.
- SHAMT, 1, left-shift amount applied in mode 2'b11. Required: N_BUS_IN + SHAMT <= N_BUS.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  upstream has a valid immediate.
- o_ready  out  1  stage can accept an input this cycle.
- i_signal  in  N_BUS_IN  raw immediate field.
- i_mode  in  2  extension mode, sampled with i_signal.
- o_valid  out  1  o_signal holds a valid result.
- i_ready  in  1  downstream accepts o_signal this cycle.
- o_signal  out  N_BUS  extended result.
- o_mode  out  2  mode that produced o_signal, travelling with the data.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (i_clk, i_rst_n).
  - While i_rst_n = 0 at a rising edge: o_valid=0, o_ready=1, o_signal=0, o_mode=0; skid entry invalid and cleared.
  - Reset mid-operation discards all held results without emitting them.
- Handshakes:
  - Accept = i_valid & o_ready.
  - Transfer = o_valid & i_ready.
  - i_signal and i_mode are sampled only on accept.
- Arithmetic (combinational on the input, result registered), with E = N_BUS - N_BUS_IN:
  - 2'b00 zero-extend: {E zeros, i_signal}.
  - 2'b01 sign-extend: {E copies of i_signal[N_BUS_IN-1], i_signal}.
  - 2'b10 upper-place: {i_signal, E zeros}.
  - 2'b11 branch offset: sign-extend(i_signal) << SHAMT. Bits shifted out are discarded; low bits are zero.
- Latency: exactly 1 cycle from accept to o_valid when the output register is free.
- State machine (occupancy):
  - EMPTY: o_valid=0, skid invalid.
  - ONE: o_valid=1, skid invalid.
  - FULL: o_valid=1, skid valid.
  - o_ready = (state != FULL). o_ready is driven from a register and has no combinational dependence on i_ready.
- Transitions:
  - EMPTY + accept -> ONE (output register loaded).
  - ONE + accept + transfer -> ONE (output register reloaded with the new value; 1 result/cycle).
  - ONE + accept + !transfer -> FULL (new value goes to skid).
  - ONE + !accept + transfer -> EMPTY.
  - FULL + transfer -> ONE (skid moves to output register, skid invalidated). No accept is possible in FULL.
  - All other combinations hold state and data.
- Ordering: results leave in acceptance order; no loss, no duplication.
- Stability: o_signal and o_mode stay stable while o_valid=1 and i_ready=0.
- Invalid i_valid: X on i_signal while i_valid=0 must not propagate to any register.

Test Plan:
Defaults for all scenarios: N_BUS=16, N_BUS_IN=11, SHAMT=1, i_ready=1 unless noted.
1. Mode sweep:
   - mode 00, 11'h7FF -> 16'h07FF
   - mode 01, 11'h400 -> 16'hFC00; mode 01, 11'h3FF -> 16'h03FF
   - mode 10, 11'h001 -> 16'h0020
   - mode 11, 11'h7FF -> 16'hFFFE; mode 11, 11'h400 -> 16'hF800
   - each result appears with o_valid=1 on the cycle after accept, with o_mode echoed.
2. Streaming: 8 back-to-back inputs with i_valid=1 and i_ready held at 1 -> 8 consecutive o_valid cycles, o_ready never deasserts, outputs in order.
3. Backpressure:
   - i_ready=0; offer 11'h001, 11'h002, 11'h003 (mode 00) -> first two accepted, o_ready=0 from the cycle after the second accept, third held upstream.
   - raise i_ready -> outputs 16'h0001, 16'h0002, 16'h0003 in order, none lost or duplicated.
4. Stall stability: with state FULL and i_ready=0 for 5 cycles, o_signal and o_mode are unchanged every cycle; i_signal is toggled with i_valid=0 during the stall and has no effect.
5. Reset mid-operation: reach FULL, then drive i_rst_n=0 for one edge -> next cycle o_valid=0, o_ready=1, o_signal=16'h0000; after release, a new input 11'h005 mode 01 -> 16'h0005 with 1-cycle latency.
6. Simultaneous accept and transfer in ONE: state stays ONE and throughput holds at 1 result per cycle; a random valid/ready soak of 10k cycles against a reference model reports zero mismatches.

Source files
------------

// File: rtl/sig_ext_stage_if.sv
// Handshake bundle for the immediate-extension stage: upstream valid/ready with the
// raw immediate, downstream valid/ready with the extended result.
interface sig_ext_stage_if #(
    parameter int N_BUS    = 16,
    parameter int N_BUS_IN = 11
);
    logic                i_valid;
    logic                o_ready;
    logic [N_BUS_IN-1:0] i_signal;
    logic [1:0]          i_mode;
    logic                o_valid;
    logic                i_ready;
    logic [N_BUS-1:0]    o_signal;
    logic [1:0]          o_mode;

    modport slave (
        input  i_valid, i_signal, i_mode, i_ready,
        output o_ready, o_valid, o_signal, o_mode
    );

    modport master (
        output i_valid, i_signal, i_mode, i_ready,
        input  o_ready, o_valid, o_signal, o_mode
    );
endinterface

// File: rtl/sig_ext_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer. Ready comes
// straight from a register, so there is no combinational path from i_ready.
module sig_ext_stage #(
    parameter int N_BUS    = 16,
    parameter int N_BUS_IN = 11,
    parameter int SHAMT    = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    sig_ext_stage_if.slave  bus
);
    localparam int EXT_W = N_BUS - N_BUS_IN;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t              state_r;
    logic                valid_r;
    logic                ready_r;
    logic [N_BUS-1:0]    out_signal_r;
    logic [1:0]          out_mode_r;
    logic [N_BUS-1:0]    skid_signal_r;
    logic [1:0]          skid_mode_r;

    logic                accept_s;
    logic                transfer_s;
    logic [N_BUS-1:0]    ext_s;

    function automatic logic [N_BUS-1:0] ext_fn(input logic [N_BUS_IN-1:0] sig,
                                               input logic [1:0]          mode);
        logic [N_BUS-1:0] sext_v;
        sext_v = {{EXT_W{sig[N_BUS_IN-1]}}, sig};
        case (mode)
            2'b00:   ext_fn = {{EXT_W{1'b0}}, sig};
            2'b01:   ext_fn = sext_v;
            2'b10:   ext_fn = {sig, {EXT_W{1'b0}}};
            2'b11:   ext_fn = sext_v << SHAMT;
            default: ext_fn = {N_BUS{1'b0}};
        endcase
    endfunction

    assign accept_s   = bus.i_valid & ready_r;
    assign transfer_s = valid_r & bus.i_ready;
    assign ext_s      = ext_fn(bus.i_signal, bus.i_mode);

    assign bus.o_ready  = ready_r;
    assign bus.o_valid  = valid_r;
    assign bus.o_signal = out_signal_r;
    assign bus.o_mode   = out_mode_r;

    // Occupancy FSM; data registers load only on accept, so idle inputs never leak in.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r       <= ST_EMPTY;
            valid_r       <= 1'b0;
            ready_r       <= 1'b1;
            out_signal_r  <= {N_BUS{1'b0}};
            out_mode_r    <= 2'b00;
            skid_signal_r <= {N_BUS{1'b0}};
            skid_mode_r   <= 2'b00;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        out_signal_r <= ext_s;
                        out_mode_r   <= bus.i_mode;
                        valid_r      <= 1'b1;
                        state_r      <= ST_ONE;
                    end else begin
                        state_r      <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && transfer_s) begin
                        out_signal_r <= ext_s;
                        out_mode_r   <= bus.i_mode;
                    end else if (accept_s) begin
                        skid_signal_r <= ext_s;
                        skid_mode_r   <= bus.i_mode;
                        ready_r       <= 1'b0;
                        state_r       <= ST_FULL;
                    end else if (transfer_s) begin
                        valid_r <= 1'b0;
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (transfer_s) begin
                        out_signal_r  <= skid_signal_r;
                        out_mode_r    <= skid_mode_r;
                        skid_signal_r <= {N_BUS{1'b0}};
                        skid_mode_r   <= 2'b00;
                        ready_r       <= 1'b1;
                        state_r       <= ST_ONE;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sig_ext_stage.sv
// Directed bench for sig_ext_stage with hand-computed vectors, followed by a
// random valid/ready soak against a queue-based reference.
module tb_sig_ext_stage;
    logic clk_s   = 1'b0;
    logic rst_n_s = 1'b0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    sig_ext_stage_if #(.N_BUS(16), .N_BUS_IN(11)) bus_if ();

    sig_ext_stage #(.N_BUS(16), .N_BUS_IN(11), .SHAMT(1)) dut (
        .i_clk   (clk_s),
        .i_rst_n (rst_n_s),
        .bus     (bus_if)
    );

    always #5 clk_s = ~clk_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic drive(input logic v, input logic [10:0] s, input logic [1:0] m);
        bus_if.i_valid  = v;
        bus_if.i_signal = s;
        bus_if.i_mode   = m;
    endtask

    function automatic logic [15:0] model_ext(input logic [10:0] s, input logic [1:0] m);
        logic signed [15:0] sx;
        sx = $signed(s);
        case (m)
            2'd0:    return {5'd0, s};
            2'd1:    return sx;
            2'd2:    return s * 16'd32;
            default: return sx * 16'sd2;
        endcase
    endfunction

    typedef struct { logic [1:0] m; logic [10:0] s; logic [15:0] e; } vec_t;
    vec_t vecs[7];
    logic [15:0] q_data[$];
    logic [1:0]  q_mode[$];

    initial begin
        vecs[0] = '{2'b00, 11'h7FF, 16'h07FF};
        vecs[1] = '{2'b01, 11'h400, 16'hFC00};
        vecs[2] = '{2'b01, 11'h3FF, 16'h03FF};
        vecs[3] = '{2'b10, 11'h001, 16'h0020};
        vecs[4] = '{2'b11, 11'h7FF, 16'hFFFE};
        vecs[5] = '{2'b11, 11'h400, 16'hF800};
        vecs[6] = '{2'b10, 11'h7FF, 16'hFFE0};

        bus_if.i_ready = 1'b1;
        drive(1'b0, 11'h000, 2'b00);
        step();
        step();
        check("rst_valid", bus_if.o_valid, 1'b0);
        check("rst_ready", bus_if.o_ready, 1'b1);
        check("rst_signal", bus_if.o_signal, 16'h0000);
        check("rst_mode", bus_if.o_mode, 2'b00);
        rst_n_s = 1'b1;
        step();

        // 1. mode sweep, one-cycle latency
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].s, vecs[i].m);
            step();
            check("sweep_valid", bus_if.o_valid, 1'b1);
            check("sweep_signal", bus_if.o_signal, vecs[i].e);
            check("sweep_mode", bus_if.o_mode, vecs[i].m);
        end
        drive(1'b0, 11'h000, 2'b00);
        step();
        check("sweep_drain", bus_if.o_valid, 1'b0);

        // 2. streaming at full rate
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 11'h010 + 11'(k), 2'b00);
            step();
            check("stream_valid", bus_if.o_valid, 1'b1);
            check("stream_ready", bus_if.o_ready, 1'b1);
            check("stream_signal", bus_if.o_signal, 16'h0010 + 16'(k));
        end
        drive(1'b0, 11'h000, 2'b00);
        step();
        check("stream_drain", bus_if.o_valid, 1'b0);

        // 3. backpressure fills output + skid
        bus_if.i_ready = 1'b0;
        drive(1'b1, 11'h001, 2'b00);
        step();
        check("bp_ready1", bus_if.o_ready, 1'b1);
        check("bp_signal1", bus_if.o_signal, 16'h0001);
        drive(1'b1, 11'h002, 2'b00);
        step();
        check("bp_ready_full", bus_if.o_ready, 1'b0);
        drive(1'b1, 11'h003, 2'b00);
        step();
        check("bp_held_ready", bus_if.o_ready, 1'b0);
        check("bp_held_signal", bus_if.o_signal, 16'h0001);

        // 4. stall stability with idle input toggling
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, (k % 2 == 0) ? 11'h555 : 11'h2AA, 2'(k));
            step();
            check("stall_valid", bus_if.o_valid, 1'b1);
            check("stall_signal", bus_if.o_signal, 16'h0001);
            check("stall_mode", bus_if.o_mode, 2'b00);
        end

        drive(1'b1, 11'h003, 2'b00);
        bus_if.i_ready = 1'b1;
        step();
        check("bp_out2", bus_if.o_signal, 16'h0002);
        check("bp_ready_back", bus_if.o_ready, 1'b1);
        step();
        check("bp_out3", bus_if.o_signal, 16'h0003);
        check("bp_out3_valid", bus_if.o_valid, 1'b1);
        drive(1'b0, 11'h000, 2'b00);
        step();
        check("bp_drain", bus_if.o_valid, 1'b0);

        // 5. reset while FULL
        bus_if.i_ready = 1'b0;
        drive(1'b1, 11'h00A, 2'b01);
        step();
        drive(1'b1, 11'h00B, 2'b11);
        step();
        check("pre_rst_full", bus_if.o_ready, 1'b0);
        drive(1'b0, 11'h000, 2'b00);
        rst_n_s = 1'b0;
        step();
        check("mid_rst_valid", bus_if.o_valid, 1'b0);
        check("mid_rst_ready", bus_if.o_ready, 1'b1);
        check("mid_rst_signal", bus_if.o_signal, 16'h0000);
        rst_n_s = 1'b1;
        bus_if.i_ready = 1'b1;
        drive(1'b1, 11'h005, 2'b01);
        step();
        check("post_rst_valid", bus_if.o_valid, 1'b1);
        check("post_rst_signal", bus_if.o_signal, 16'h0005);
        check("post_rst_mode", bus_if.o_mode, 2'b01);
        drive(1'b0, 11'h000, 2'b00);
        step();
        check("post_rst_drain", bus_if.o_valid, 1'b0);

        // 6. random soak against queue reference
        for (int c = 0; c < 10000; c++) begin
            logic v, r, acc, xfer;
            logic [10:0] s;
            logic [1:0]  m;
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 3) != 0);
            s = 11'($urandom);
            m = 2'($urandom);
            drive(v, s, m);
            bus_if.i_ready = r;
            check("soak_valid", bus_if.o_valid, q_data.size() > 0);
            check("soak_ready", bus_if.o_ready, q_data.size() < 2);
            if (q_data.size() > 0) begin
                check("soak_signal", bus_if.o_signal, q_data[0]);
                check("soak_mode", bus_if.o_mode, q_mode[0]);
            end
            xfer = (q_data.size() > 0) && r;
            acc  = v && (q_data.size() < 2);
            if (xfer) begin
                void'(q_data.pop_front());
                void'(q_mode.pop_front());
            end
            if (acc) begin
                q_data.push_back(model_ext(s, m));
                q_mode.push_back(m);
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
